cpu_controller: RTL
===================

Name: cpu_controller

Overview:
- Instruction-sequencing controller for the 8-opcode, 5-bit-address RISC CPU.
- Steps through an 8-phase fetch/execute cycle and drives the control strobes consumed by the program counter, instruction register, accumulator, memory and data-bus driver.
- It is the driving end of the PC's ld_pc/inc_pc/halt interface.
- Sticky halt on HLT until reset.

Parameters:
- None. Opcode encoding and phase encoding are fixed by the shared ISA package.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  3  current instruction opcode from the instruction register (stable from phase IDLE onward)
- zero  in  1  accumulator-equals-zero flag
- sel  out  1  address mux select: 1 = PC address, 0 = IR operand address
- rd  out  1  memory read strobe
- ld_ir  out  1  instruction register load
- inc_pc  out  1  PC increment
- ld_pc  out  1  PC load from IR operand field
- halt  out  1  halt indication to the PC and the system
- ld_ac  out  1  accumulator load
- data_e  out  1  accumulator-to-data-bus driver enable
- wr  out  1  memory write strobe
- phase  out  3  current phase, for debug and trace

Behaviour:
Opcodes:
- HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.

State:
- 3-bit phase register: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- 1-bit halted flag.

Reset (async, rst_n=0):
- phase=INST_ADDR, halted=0.
- Outputs therefore equal sel=1, all others 0, phase=0.

Phase sequencing:
- Each clock phase advances by 1.
- STORE wraps to INST_ADDR, so one instruction takes exactly 8 cycles.
- When halted=1, phase holds at OP_ADDR.

Outputs:
- Combinational from phase, opcode, zero and halted.
- Unlisted outputs are 0.

Per-phase output rules:
- INST_ADDR: sel=1.
- INST_FETCH: sel=1, rd=1.
- INST_LOAD: sel=1, rd=1, ld_ir=1.
- IDLE: sel=1, rd=1, ld_ir=1.
- OP_ADDR:
  - If opcode==HLT or halted: halt=1, inc_pc=0.
  - Else: inc_pc=1.
  - On the clock edge in OP_ADDR with opcode==HLT, halted is set to 1.
- OP_FETCH: rd=ALUOP.
- ALU_OP: rd=ALUOP, ld_ac=ALUOP, inc_pc=(SKZ and zero), ld_pc=JMP, data_e=STO.
- STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.

Interface to the PC:
- inc_pc and ld_pc are never both 1 in the same cycle.
- Normal flow produces exactly one inc_pc pulse per instruction; SKZ with zero=1 produces a second pulse in ALU_OP.
- JMP asserts ld_pc for two consecutive cycles (ALU_OP, STORE) with the same target; the second load is idempotent.

Halt:
- halted is sticky. Only rst_n clears it; the opcode changing while halted does not clear it.
- While halted: halt=1, no rd/wr/ld_* strobes, phase=4.
- Reset asserted mid-instruction in any phase aborts immediately: outputs go to reset values asynchronously. After rst_n deasserts, the first edge moves to INST_FETCH.

Memory strobes:
- wr is asserted only in STORE and only for STO.
- rd and wr are never both 1.
- data_e is 1 during ALU_OP and STORE for STO, so the bus is driven one cycle before and during wr.

Decomposition:
- Shared package risc_pkg holds:
  - opcode constants (OP_HLT through OP_JMP)
  - phase constants (PH_INST_ADDR through PH_STORE)
  - OPCODE_W=3, ADDR_W=5
- No sub-module. Phase register, halted flag and output decode live in one module.

Test Plan:
1. Reset then run with opcode=ADD for 8 cycles -> phases 0..7 in order; rd=1 in phases 1-3 and 5-7; ld_ir=1 in phases 2-3; inc_pc=1 only in phase 4; ld_ac=1 in phases 6-7; wr never asserted.
2. opcode=STO -> rd=0 in phases 5-7; data_e=1 in phases 6-7; wr=1 only in phase 7; ld_ac=0 throughout.
3. opcode=SKZ with zero=1 -> inc_pc=1 in phase 4 and phase 6 (PC advances by 2). With zero=0 -> inc_pc=1 in phase 4 only.
4. opcode=JMP -> ld_pc=1 in phases 6 and 7; inc_pc=1 only in phase 4; never inc_pc and ld_pc in the same cycle.
5. opcode=HLT -> phase 4 shows halt=1, inc_pc=0. Then hold 20 cycles: phase stays 4, halt=1, all strobes 0. Change opcode to ADD -> still halted. Pulse rst_n low -> phase=0, halt=0, sel=1.
6. rst_n asserted asynchronously mid-cycle in phase 6 with opcode=STO -> data_e, wr and phase drop to 0 immediately without waiting for clk. After release, the sequence restarts at phase 0→1.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared ISA definitions for the 8-opcode, 5-bit-address RISC CPU.
// Holds opcode and phase encodings plus the basic field widths used by
// the datapath blocks and the instruction-sequencing controller.
package risc_pkg;

    localparam int OPCODE_W = 3;
    localparam int ADDR_W   = 5;

    typedef enum logic [OPCODE_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction-sequencing controller: walks the 8-phase fetch/execute cycle
// and decodes the control strobes for PC, IR, accumulator, memory and the
// data-bus driver. HLT parks the sequencer in OP_ADDR until reset.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   opcode      - current instruction opcode from the IR
//   zero        - accumulator-equals-zero flag
//   sel         - address mux select (1 = PC, 0 = IR operand)
//   rd, wr      - memory read / write strobes
//   ld_ir       - instruction register load
//   inc_pc      - PC increment
//   ld_pc       - PC load from IR operand field
//   halt        - halt indication
//   ld_ac       - accumulator load
//   data_e      - accumulator-to-data-bus driver enable
//   phase       - current phase, debug/trace
module cpu_controller
    import risc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                halt,
    output logic                ld_ac,
    output logic                data_e,
    output logic                wr,
    output logic [2:0]          phase
);

    phase_t cur_phase;
    logic   halted;
    logic   aluop;
    logic   op_hlt;
    logic   op_skz;
    logic   op_sto;
    logic   op_jmp;

    assign aluop  = is_aluop(opcode);
    assign op_hlt = (opcode == OP_HLT);
    assign op_skz = (opcode == OP_SKZ);
    assign op_sto = (opcode == OP_STO);
    assign op_jmp = (opcode == OP_JMP);

    // The edge that latches HLT also holds the phase, so the halted
    // machine never shows anything but OP_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_phase <= PH_INST_ADDR;
            halted    <= 1'b0;
        end else if (halted || (cur_phase == PH_OP_ADDR && op_hlt)) begin
            cur_phase <= PH_OP_ADDR;
            halted    <= 1'b1;
        end else begin
            cur_phase <= phase_t'(cur_phase + 3'd1);
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        halt   = 1'b0;
        ld_ac  = 1'b0;
        data_e = 1'b0;
        wr     = 1'b0;
        unique case (cur_phase)
            PH_INST_ADDR: begin
                sel = 1'b1;
            end
            PH_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                if (op_hlt || halted) halt   = 1'b1;
                else                  inc_pc = 1'b1;
            end
            PH_OP_FETCH: begin
                rd = aluop;
            end
            PH_ALU_OP: begin
                rd     = aluop;
                ld_ac  = aluop;
                inc_pc = op_skz && zero;  // skip next instruction
                ld_pc  = op_jmp;
                data_e = op_sto;          // drive bus a cycle ahead of wr
            end
            PH_STORE: begin
                rd     = aluop;
                ld_ac  = aluop;
                ld_pc  = op_jmp;          // repeat load, same target
                wr     = op_sto;
                data_e = op_sto;
            end
            default: ;
        endcase
    end

    assign phase = cur_phase;

endmodule
